// File: rtl/serial_loader.sv
// ---------------------------------------------------------------------------
// serial_loader
//
// Upstream feeder for a 1-bit load-enabled register. A parallel word is
// accepted over a valid/ready handshake and then emitted one bit per cycle
// on bit_out, each bit qualified by a one-cycle ld_out strobe. The hold
// input stalls emission while keeping the current bit position.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   word_in     parallel word to serialize (WIDTH bits)
//   word_valid  word_in is valid
//   word_ready  block can accept a word (state is IDLE)
//   hold        stall request, only honoured while shifting
//   bit_out     registered serial data bit
//   ld_out      registered load strobe, one cycle per emitted bit
//   busy        a word is in flight (state is not IDLE)
//   done        registered one-cycle pulse after the last bit
//
// Parameters:
//   WIDTH       bits per word (>= 2)
//   MSB_FIRST   0: bit 0 is emitted first, 1: bit WIDTH-1 is emitted first
// ---------------------------------------------------------------------------
module serial_loader #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_valid,
  output logic             word_ready,
  input  logic             hold,
  output logic             bit_out,
  output logic             ld_out,
  output logic             busy,
  output logic             done
);

  localparam int              IDXW     = $clog2(WIDTH);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_reg;
  logic [WIDTH-1:0]  word_reg;
  logic [IDXW-1:0]   idx_reg;
  logic              bit_out_reg;
  logic              ld_out_reg;
  logic              done_reg;

  // The emission order is resolved once, when the word is latched, so the
  // shifting logic always walks the stored word from index 0 upwards.
  logic [WIDTH-1:0]  word_ordered;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_order
      if (MSB_FIRST != 0) begin : g_msb
        assign word_ordered[gi] = word_in[WIDTH-1-gi];
      end else begin : g_lsb
        assign word_ordered[gi] = word_in[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      word_reg    <= '0;
      idx_reg     <= '0;
      bit_out_reg <= 1'b0;
      ld_out_reg  <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          ld_out_reg <= 1'b0;
          done_reg   <= 1'b0;
          if (word_valid) begin
            word_reg  <= word_ordered;
            idx_reg   <= '0;
            state_reg <= SHIFT;
          end
        end

        SHIFT: begin
          done_reg <= 1'b0;
          if (hold) begin
            // Stall: bit_out keeps its value so the downstream register
            // never sees a change without a load strobe.
            ld_out_reg <= 1'b0;
          end else begin
            bit_out_reg <= word_reg[idx_reg];
            ld_out_reg  <= 1'b1;
            // idx stops on the last bit instead of wrapping; it is
            // cleared again on the next acceptance.
            if (idx_reg == LAST_IDX) begin
              state_reg <= DONE;
            end else begin
              idx_reg <= idx_reg + 1'b1;
            end
          end
        end

        DONE: begin
          ld_out_reg <= 1'b0;
          done_reg   <= 1'b1;
          state_reg  <= IDLE;
        end

        default: begin
          ld_out_reg <= 1'b0;
          done_reg   <= 1'b0;
          state_reg  <= IDLE;
        end
      endcase
    end
  end

  assign word_ready = (state_reg == IDLE);
  assign busy       = (state_reg != IDLE);
  assign bit_out    = bit_out_reg;
  assign ld_out     = ld_out_reg;
  assign done       = done_reg;

endmodule

// File: tb/tb_serial_loader.sv
// ---------------------------------------------------------------------------
// tb_serial_loader
//
// Directed bench for serial_loader. Two instances share all inputs:
// u_lsb (MSB_FIRST=0) and u_msb (MSB_FIRST=1). Each feeds a small model of
// the downstream 1-bit load-enabled register. Outputs are sampled 1 ns
// after the rising edge; expected bit sequences are written in emission
// order (leftmost bit emitted first).
// ---------------------------------------------------------------------------
module tb_serial_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] word_in;
  logic       word_valid;
  logic       hold;

  logic       ready0, bit0, ld0, busy0, done0;
  logic       ready1, bit1, ld1, busy1, done1;
  logic       reg1_lsb, reg1_msb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_loader #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .word_in(word_in), .word_valid(word_valid),
    .word_ready(ready0), .hold(hold), .bit_out(bit0), .ld_out(ld0),
    .busy(busy0), .done(done0)
  );

  serial_loader #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst_n(rst_n), .word_in(word_in), .word_valid(word_valid),
    .word_ready(ready1), .hold(hold), .bit_out(bit1), .ld_out(ld1),
    .busy(busy1), .done(done1)
  );

  // Downstream Reg1 models: load in on ld.
  always_ff @(posedge clk) begin
    if (ld0) reg1_lsb <= bit0;
    if (ld1) reg1_msb <= bit1;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one word with no holds and check the full serial sequence on
  // both instances, the done pulse and the downstream register value.
  task automatic run_word(input string name, input logic [7:0] w,
                          input logic [0:7] s0, input logic [0:7] s1);
    word_in    = w;
    word_valid = 1'b1;
    tick();
    check({name, " accept"}, {5'd0, busy0, ready0, ld0}, 8'b100);
    word_valid = 1'b0;
    word_in    = ~w;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("%s lsb bit%0d", name, i), {6'd0, ld0, bit0}, {6'd0, 1'b1, s0[i]});
      check($sformatf("%s msb bit%0d", name, i), {6'd0, ld1, bit1}, {6'd0, 1'b1, s1[i]});
    end
    tick();
    check({name, " lsb done"}, {4'd0, ld0, done0, ready0, busy0}, 8'b0110);
    check({name, " msb done"}, {4'd0, ld1, done1, ready1, busy1}, 8'b0110);
    check({name, " lsb reg1"}, {7'd0, reg1_lsb}, {7'd0, s0[7]});
    check({name, " msb reg1"}, {7'd0, reg1_msb}, {7'd0, s1[7]});
    tick();
    check({name, " done clears"}, {6'd0, done0, done1}, 8'b00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [0:7] exp_seq;

    rst_n      = 1'b0;
    word_in    = 8'h00;
    word_valid = 1'b0;
    hold       = 1'b0;
    tick();
    tick();
    check("reset outputs", {3'd0, bit0, ld0, done0, busy0, ready0}, 8'b00001);
    check("reset outputs msb", {3'd0, bit1, ld1, done1, busy1, ready1}, 8'b00001);
    rst_n = 1'b1;
    tick();

    // 0xA5: LSB-first and MSB-first both give 1,0,1,0,0,1,0,1.
    run_word("a5", 8'hA5, 8'b10100101, 8'b10100101);
    // 0x0F: LSB-first 1,1,1,1,0,0,0,0; MSB-first 0,0,0,0,1,1,1,1.
    run_word("0f", 8'h0F, 8'b11110000, 8'b00001111);

    // Hold for two cycles after the 4th bit of 0x3C (0,0,1,1 | 1,1,0,0).
    exp_seq    = 8'b00111100;
    word_in    = 8'h3C;
    word_valid = 1'b1;
    tick();                                   // E0
    word_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin         // E1..E4
      tick();
      check($sformatf("hold pre bit%0d", i), {6'd0, ld0, bit0}, {6'd0, 1'b1, exp_seq[i]});
    end
    hold = 1'b1;
    for (int i = 0; i < 2; i++) begin         // E5, E6 stalled
      tick();
      check($sformatf("hold stall%0d", i), {5'd0, ld0, bit0, busy0}, 8'b011);
    end
    hold = 1'b0;
    for (int i = 4; i < 8; i++) begin         // E7..E10
      tick();
      check($sformatf("hold post bit%0d", i), {6'd0, ld0, bit0}, {6'd0, 1'b1, exp_seq[i]});
      check($sformatf("hold no done%0d", i), {7'd0, done0}, 8'd0);
    end
    tick();                                   // E11
    check("hold done", {5'd0, ld0, done0, ready0}, 8'b011);
    tick();

    // Back-to-back with word_valid held: 0x01 then 0x80.
    word_in    = 8'h01;
    word_valid = 1'b1;
    tick();                                   // E0
    word_in = 8'h80;
    exp_seq = 8'b10000000;
    for (int i = 0; i < 8; i++) begin         // E1..E8
      tick();
      check($sformatf("b2b w1 lsb bit%0d", i), {5'd0, ready0, ld0, bit0}, {5'd0, 1'b0, 1'b1, exp_seq[i]});
      check($sformatf("b2b w1 msb bit%0d", i), {6'd0, ld1, bit1}, {6'd0, 1'b1, exp_seq[7-i]});
    end
    tick();                                   // E9
    check("b2b gap", {5'd0, ld0, done0, ready0}, 8'b011);
    tick();                                   // E10: second acceptance
    check("b2b accept2", {4'd0, busy0, ready0, ld0, done0}, 8'b1000);
    word_valid = 1'b0;
    word_in    = 8'h55;
    exp_seq    = 8'b00000001;
    for (int i = 0; i < 8; i++) begin         // E11..E18
      tick();
      check($sformatf("b2b w2 lsb bit%0d", i), {6'd0, ld0, bit0}, {6'd0, 1'b1, exp_seq[i]});
      check($sformatf("b2b w2 msb bit%0d", i), {6'd0, ld1, bit1}, {6'd0, 1'b1, exp_seq[7-i]});
    end
    tick();                                   // E19
    check("b2b done2", {6'd0, done0, ready0}, 8'b11);
    tick();

    // Reset in the middle of 0xFF after three bits.
    word_in    = 8'hFF;
    word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
    tick();
    tick();
    tick();
    check("pre-reset bit", {6'd0, ld0, bit0}, 8'b11);
    rst_n = 1'b0;
    #2;
    check("async reset", {3'd0, bit0, ld0, done0, busy0, ready0}, 8'b00001);
    check("async reset msb", {3'd0, bit1, ld1, done1, busy1, ready1}, 8'b00001);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("post-reset quiet%0d", i), {5'd0, ld0, ld1, busy0}, 8'b000);
    end

    // Idle robustness: hold toggling, no valid.
    for (int i = 0; i < 20; i++) begin
      hold = ~hold;
      tick();
      check($sformatf("idle%0d", i), {4'd0, ld0, done0, busy0, ready0}, 8'b0001);
    end
    hold = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
